fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a small instruction memory and buffers
// fetched words in a 2-entry queue, with redirect and halt-at-end-of-memory.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MEM_SIZE = 5
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted
);

   typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

   localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);

   state_t            state_r;
   state_t            state_next_s;
   logic [31:0]       fetch_pc_r;
   logic [31:0]       fetch_pc_next_s;
   logic [1:0]        count_r;
   logic [1:0]        count_next_s;
   logic [1:0][31:0]  pc_q_r;
   logic [1:0][31:0]  instr_q_r;
   logic              in_range_s;
   logic              pop_s;
   logic              push_s;
   logic              wpos_s;
   logic [31:0]       target_s;

   assign in_range_s = (fetch_pc_r[31:2] < MEM_WORDS);
   assign target_s   = redirect_pc & 32'hFFFF_FFFC;
   assign pop_s      = out_valid && out_ready;
   assign push_s     = (state_r == RUN) && !redirect_valid && in_range_s &&
                       ((count_r != 2'd2) || pop_s);
   // Slot the new entry lands in once any pop has shifted the queue forward.
   assign wpos_s     = (count_r == 2'd2) || ((count_r == 2'd1) && !pop_s);

   assign imem_addr  = fetch_pc_r;
   assign out_valid  = (count_r != 2'd0);
   assign out_pc     = pc_q_r[0];
   assign out_instr  = instr_q_r[0];
   assign halted     = (state_r == HALT);

   // Next-state logic: redirect overrides fetch, pop and halt entry.
   always_comb begin
      state_next_s    = state_r;
      count_next_s    = count_r;
      fetch_pc_next_s = fetch_pc_r;
      if (redirect_valid) begin
         state_next_s    = RUN;
         count_next_s    = 2'd0;
         fetch_pc_next_s = target_s;
      end else begin
         count_next_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
         if (push_s) begin
            fetch_pc_next_s = fetch_pc_r + 32'd4;
         end else begin
            fetch_pc_next_s = fetch_pc_r;
         end
         case (state_r)
            RUN: begin
               if (!in_range_s && (count_r == 2'd0)) begin
                  state_next_s = HALT;
               end else begin
                  state_next_s = RUN;
               end
            end
            HALT:    state_next_s = HALT;
            default: state_next_s = RUN;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= RUN;
         count_r    <= 2'd0;
         fetch_pc_r <= RESET_PC;
      end else begin
         state_r    <= state_next_s;
         count_r    <= count_next_s;
         fetch_pc_r <= fetch_pc_next_s;
      end
   end

   // Queue storage: shift on pop, then write the fetched word behind the survivors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q_r    <= '{default: 32'd0};
         instr_q_r <= '{default: 32'd0};
      end else if (!redirect_valid) begin
         if (pop_s) begin
            pc_q_r[0]    <= pc_q_r[1];
            instr_q_r[0] <= instr_q_r[1];
         end
         if (push_s) begin
            pc_q_r[wpos_s]    <= fetch_pc_r;
            instr_q_r[wpos_s] <= imem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then randomized
// ready/redirect/reset traffic against an in-order expected-stream model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          MEM_SIZE = 5;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        halted;

   logic [31:0] mem [16];
   xfer_t       exp_q [$];
   xfer_t       head;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          halt_due = 0;
   bit          exp_halted = 1'b0;
   bit          after_break = 1'b1;

   fetch_unit #(.RESET_PC(RESET_PC), .MEM_SIZE(MEM_SIZE)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halted(halted)
   );

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[5:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Everything the consumer should see, in order, for a stream starting at start.
   task automatic load_stream(input logic [31:0] start);
      exp_q.delete();
      for (int w = int'(start[31:2]); w < MEM_SIZE; w++)
         exp_q.push_back({32'(w * 4), mem[w]});
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: checks state on the falling edge, then consumes this cycle's transfer.
   always @(negedge clk) begin
      if (rst) begin
         chk("valid_in_reset", {31'd0, out_valid}, 32'd0);
         chk("halted_in_reset", {31'd0, halted}, 32'd0);
         load_stream(RESET_PC);
         halt_due    = 0;
         exp_halted  = 1'b0;
         after_break = 1'b1;
      end else begin
         if (halt_due > 0) begin
            halt_due--;
            if (halt_due == 0) exp_halted = 1'b1;
         end
         chk("halted", {31'd0, halted}, {31'd0, exp_halted});
         if (after_break)
            chk("valid_after_restart", {31'd0, out_valid}, 32'd0);
         else
            chk("valid_vs_pending", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_xfer: got pc %h expected no transfer", out_pc);
            end else begin
               head = exp_q.pop_front();
               chk("xfer_pc", out_pc, head.pc);
               chk("xfer_instr", out_instr, head.instr);
               if (exp_q.size() == 0) halt_due = 2;
            end
         end
         after_break = 1'b0;
         if (redirect_valid) begin
            load_stream(redirect_pc);
            exp_halted  = 1'b0;
            halt_due    = (exp_q.size() == 0) ? 2 : 0;
            after_break = 1'b1;
         end
      end
   end

   initial begin
      mem[0] = 32'h0000_3083;
      mem[1] = 32'h0080_3103;
      mem[2] = 32'h0020_81b3;
      mem[3] = 32'h0030_0f93;
      mem[4] = 32'h0000_0013;
      for (int i = 5; i < 16; i++) mem[i] = $urandom;

      // Straight run to the end of memory.
      step(2);
      chk("imem_addr_in_reset", imem_addr, RESET_PC);
      rst = 1'b0;
      step(10);
      chk("halted_after_run", {31'd0, halted}, 32'd1);
      chk("imem_addr_at_halt", imem_addr, 32'd20);

      // Backpressure fills the queue, then drains back-to-back.
      rst = 1'b1; out_ready = 1'b0;
      step(1);
      rst = 1'b0;
      step(4);
      chk("bp_imem_addr_hold", imem_addr, 32'd8);
      chk("bp_head_pc", out_pc, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step(10);

      // Redirect with an unaligned target while full.
      rst = 1'b1; out_ready = 1'b0;
      step(1);
      rst = 1'b0;
      step(4);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_000E;
      step(1);
      redirect_valid = 1'b0;
      chk("redir_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("redir_imem_addr", imem_addr, 32'h0000_000C);
      out_ready = 1'b1;
      step(1);
      chk("redir_head_pc", out_pc, 32'h0000_000C);
      chk("redir_head_instr", out_instr, 32'h0030_0f93);
      step(6);
      chk("redir_halted", {31'd0, halted}, 32'd1);

      // Leave HALT by redirect.
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0004;
      step(1);
      redirect_valid = 1'b0;
      chk("resume_not_halted", {31'd0, halted}, 32'd0);
      step(10);
      chk("rehalted", {31'd0, halted}, 32'd1);

      // Redirect coinciding with a pop at count 2.
      rst = 1'b1; out_ready = 1'b0;
      step(1);
      rst = 1'b0;
      step(3);
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
      step(1);
      redirect_valid = 1'b0;
      step(8);

      // Asynchronous reset while full.
      rst = 1'b1; out_ready = 1'b0;
      step(1);
      rst = 1'b0;
      step(3);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_imem_addr", imem_addr, RESET_PC);
      step(1);
      rst = 1'b0; out_ready = 1'b1;
      step(8);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 11) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom_range(0, 31);
            rst            = 1'b0;
         end else begin
            redirect_valid = 1'b0;
            rst            = ($urandom_range(0, 59) == 0);
         end
         step(1);
      end
      rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
      step(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
